// File: rtl/bounce_pkg.sv
// ---------------------------------------------------------------------------
// bounce_pkg
//   Shared definitions for the LED sequence counter.
//   mode_t : 2-bit run-mode encoding carried on the counter's mode input.
// ---------------------------------------------------------------------------
package bounce_pkg;

  typedef enum logic [1:0] {
    MODE_UP_WRAP   = 2'b00,
    MODE_DOWN_WRAP = 2'b01,
    MODE_BOUNCE    = 2'b10,
    MODE_HOLD      = 2'b11
  } mode_t;

endpackage

// File: rtl/tick_gen.sv
// ---------------------------------------------------------------------------
// tick_gen
//   Prescaler producing a single-cycle clock-enable every DIV_MAX+1 enabled
//   clk cycles. No derived clock is generated.
//   Ports:
//     clk     in  system clock
//     rst_btn in  asynchronous reset, active-low
//     en      in  1 = prescaler advances, 0 = prescaler holds its value
//     clear   in  synchronous restart of the prescaler to 0
//     tick    out 1 on the edge where the prescaler sits at DIV_MAX with en=1
// ---------------------------------------------------------------------------
module tick_gen #(
  parameter int DIV_WIDTH = 24,
  parameter int DIV_MAX   = 1499999
) (
  input  logic clk,
  input  logic rst_btn,
  input  logic en,
  input  logic clear,
  output logic tick
);

  localparam logic [DIV_WIDTH-1:0] L_DIV_MAX = DIV_WIDTH'(DIV_MAX);
  localparam logic [DIV_WIDTH-1:0] L_ONE     = DIV_WIDTH'(1);

  logic [DIV_WIDTH-1:0] r_presc;
  logic                 w_at_max;

  assign w_at_max = (r_presc == L_DIV_MAX);
  assign tick     = en && w_at_max;

  // Holding on en=0 keeps a partial period, so resuming finishes it.
  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      r_presc <= '0;
    end else if (clear) begin
      r_presc <= '0;
    end else if (en) begin
      r_presc <= w_at_max ? '0 : r_presc + L_ONE;
    end
  end

endmodule

// File: rtl/bounce_counter.sv
// ---------------------------------------------------------------------------
// bounce_counter
//   LED sequence counter with bounds LO..HI and four run modes (wrap up,
//   wrap down, bounce, hold), advanced by an internal prescaler tick.
//   Ports:
//     clk     in  system clock
//     rst_btn in  asynchronous reset, active-low
//     en      in  1 = prescaler runs, 0 = prescaler and count frozen
//     clear   in  synchronous restart to the reset state
//     mode    in  run mode (see bounce_pkg::mode_t), sampled on tick edges
//     count   out current count, registered, drives the LEDs
//     dir     out 1 = counting up, 0 = counting down
//     step    out 1-cycle pulse: count was updated on the previous edge
//     endpt   out 1-cycle pulse with step when that update wrapped/turned
// ---------------------------------------------------------------------------
module bounce_counter
  import bounce_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int LO        = 0,
  parameter int HI        = 2**WIDTH-1,
  parameter int DIV_WIDTH = 24,
  parameter int DIV_MAX   = 1499999
) (
  input  logic             clk,
  input  logic             rst_btn,
  input  logic             en,
  input  logic             clear,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             step,
  output logic             endpt
);

  localparam logic [WIDTH-1:0] L_LO  = WIDTH'(LO);
  localparam logic [WIDTH-1:0] L_HI  = WIDTH'(HI);
  localparam logic [WIDTH-1:0] L_ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_count;
  logic             r_dir;
  logic             r_step;
  logic             r_endpt;

  logic             w_tick;
  mode_t            w_mode;
  logic [WIDTH-1:0] w_count_next;
  logic             w_dir_next;
  logic             w_endpt_next;

  tick_gen #(
    .DIV_WIDTH(DIV_WIDTH),
    .DIV_MAX  (DIV_MAX)
  ) u_tick_gen (
    .clk    (clk),
    .rst_btn(rst_btn),
    .en     (en),
    .clear  (clear),
    .tick   (w_tick)
  );

  assign w_mode = mode_t'(mode);

  // Next count/dir for a tick edge. Every branch stays inside [LO,HI], so
  // no overflow path exists in WIDTH-bit arithmetic.
  always_comb begin
    w_count_next = r_count;
    w_dir_next   = r_dir;
    w_endpt_next = 1'b0;
    case (w_mode)
      MODE_UP_WRAP: begin
        w_dir_next = 1'b1;
        if (r_count == L_HI) begin
          w_count_next = L_LO;
          w_endpt_next = 1'b1;
        end else begin
          w_count_next = r_count + L_ONE;
        end
      end
      MODE_DOWN_WRAP: begin
        w_dir_next = 1'b0;
        if (r_count == L_LO) begin
          w_count_next = L_HI;
          w_endpt_next = 1'b1;
        end else begin
          w_count_next = r_count - L_ONE;
        end
      end
      MODE_BOUNCE: begin
        if (L_LO == L_HI) begin
          // Degenerate range: every tick is a turnaround at the same value.
          w_endpt_next = 1'b1;
          w_dir_next   = ~r_dir;
        end else if (r_dir) begin
          // Turn on reaching HI so each endpoint is shown once per sweep.
          if (r_count == L_HI) begin
            w_count_next = L_HI - L_ONE;
            w_dir_next   = 1'b0;
            w_endpt_next = 1'b1;
          end else begin
            w_count_next = r_count + L_ONE;
          end
        end else begin
          if (r_count == L_LO) begin
            w_count_next = L_LO + L_ONE;
            w_dir_next   = 1'b1;
            w_endpt_next = 1'b1;
          end else begin
            w_count_next = r_count - L_ONE;
          end
        end
      end
      default: begin
        // MODE_HOLD: count and dir unchanged, no endpoint event.
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      r_count <= L_LO;
      r_dir   <= 1'b1;
      r_step  <= 1'b0;
      r_endpt <= 1'b0;
    end else if (clear) begin
      r_count <= L_LO;
      r_dir   <= 1'b1;
      r_step  <= 1'b0;
      r_endpt <= 1'b0;
    end else if (w_tick) begin
      r_count <= w_count_next;
      r_dir   <= w_dir_next;
      r_step  <= 1'b1;
      r_endpt <= w_endpt_next;
    end else begin
      r_step  <= 1'b0;
      r_endpt <= 1'b0;
    end
  end

  assign count = r_count;
  assign dir   = r_dir;
  assign step  = r_step;
  assign endpt = r_endpt;

endmodule
